edge_event_detector: RTL and testbench

EDGE_EVENT_DETECTOR -- requirements
Module: edge_event_detector

---
 rtl/edge_event_detector.sv | 121 ++++++++++++
 tb/tb_edge_event_detector.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_detector.sv
// rtl/edge_event_detector.sv - per-channel synchronizer, debounce filter, edge pulses and saturating event count
// Define EDGE_EVENT_DEBOUNCE_EN to build the debounce counters; otherwise stable follows the synchronizer output.
module edge_event_detector #(
   parameter int WIDTH           = 7,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din_i,
   input  logic [1:0]       mode_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] edge_o,
   output logic [WIDTH-1:0] level_o,
   output logic             any_edge_o,
   output logic [7:0]       cnt_o
);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("WIDTH out of range");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("SYNC_STAGES out of range");
   end
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_deb
      $error("DEBOUNCE_CYCLES out of range");
   end

   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] r_stable;
   logic [WIDTH-1:0] r_edge;
   logic [7:0]       r_cnt;

   logic [WIDTH-1:0] w_sync_out;
   logic [WIDTH-1:0] w_accept;
   logic [WIDTH-1:0] w_next_edge;
   logic [5:0]       w_pop;
   logic [8:0]       w_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      end else begin
         r_sync[0] <= din_i;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      end
   end

   assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef EDGE_EVENT_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] r_deb [WIDTH];

   // A channel is accepted on the edge its run of differing samples would reach DEBOUNCE_CYCLES.
   always_comb begin
      w_accept = '0;
      for (int i = 0; i < WIDTH; i++)
         w_accept[i] = (w_sync_out[i] != r_stable[i]) && (r_deb[i] == DEB_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) r_deb[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (w_sync_out[i] == r_stable[i] || w_accept[i])
               r_deb[i] <= '0;
            else
               r_deb[i] <= r_deb[i] + CW'(1);
         end
      end
   end
`else
   assign w_accept = w_sync_out ^ r_stable;
`endif

   // The new stable value equals the sync output, so its polarity picks rising vs falling.
   always_comb begin
      w_next_edge = '0;
      for (int i = 0; i < WIDTH; i++) begin
         case (mode_i)
            2'b00:   w_next_edge[i] = w_accept[i] &  w_sync_out[i];
            2'b01:   w_next_edge[i] = w_accept[i] & ~w_sync_out[i];
            2'b10:   w_next_edge[i] = w_accept[i];
            default: w_next_edge[i] = 1'b0;
         endcase
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < WIDTH; i++) w_pop = w_pop + 6'(r_edge[i]);
      w_sum = {1'b0, r_cnt} + 9'(w_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stable <= '0;
         r_edge   <= '0;
         r_cnt    <= '0;
      end else begin
         r_stable <= r_stable ^ w_accept;
         r_edge   <= w_next_edge;
         if (clr_i)
            r_cnt <= '0;
         else if (w_sum > 9'd255)
            r_cnt <= 8'd255;
         else
            r_cnt <= w_sum[7:0];
      end
   end

   assign edge_o     = r_edge;
   assign level_o    = r_stable;
   assign any_edge_o = |r_edge;
   assign cnt_o      = r_cnt;

endmodule

// File: tb/tb_edge_event_detector.sv
// tb/tb_edge_event_detector.sv - bench for edge_event_detector against a sample-window reference model
module tb_edge_event_detector;
   localparam int WIDTH = 7;
   localparam int SYNC  = 2;
   localparam int DEB   = 4;
`ifdef EDGE_EVENT_DEBOUNCE_EN
   localparam int EFF_DEB = DEB;
`else
   localparam int EFF_DEB = 1;
`endif
   localparam int LAT = SYNC + EFF_DEB - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [WIDTH-1:0] din_i = '0;
   logic [1:0]       mode_i = 2'b00;
   logic             clr_i = 1'b0;
   logic [WIDTH-1:0] edge_o;
   logic [WIDTH-1:0] level_o;
   logic             any_edge_o;
   logic [7:0]       cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   edge_event_detector #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk(clk), .rst(rst), .din_i(din_i), .mode_i(mode_i), .clr_i(clr_i),
      .edge_o(edge_o), .level_o(level_o), .any_edge_o(any_edge_o), .cnt_o(cnt_o)
   );

   // Reference: a channel flips when the last EFF_DEB samples seen SYNC edges ago all disagree with it.
   logic [WIDTH-1:0] q_din [$];
   logic [WIDTH-1:0] m_stable = '0;
   logic [WIDTH-1:0] m_edge = '0;
   int               m_cnt = 0;
   int               m_sum;
   int               m_idx;
   bit               m_flip;
   logic             m_bit;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q_din.delete();
         m_stable = '0;
         m_edge   = '0;
         m_cnt    = 0;
      end else begin
         m_sum = m_cnt + $countones(m_edge);
         m_cnt = clr_i ? 0 : (m_sum > 255 ? 255 : m_sum);
         q_din.push_back(din_i);
         m_edge = '0;
         for (int c = 0; c < WIDTH; c++) begin
            m_flip = 1'b1;
            for (int j = 0; j < EFF_DEB; j++) begin
               m_idx = q_din.size() - 1 - SYNC - j;
               m_bit = (m_idx >= 0) ? q_din[m_idx][c] : 1'b0;
               if (m_bit == m_stable[c]) m_flip = 1'b0;
            end
            if (m_flip) begin
               m_stable[c] = ~m_stable[c];
               case (mode_i)
                  2'b00:   m_edge[c] = m_stable[c];
                  2'b01:   m_edge[c] = ~m_stable[c];
                  2'b10:   m_edge[c] = 1'b1;
                  default: m_edge[c] = 1'b0;
               endcase
            end
         end
         while (q_din.size() > SYNC + EFF_DEB + 2) void'(q_din.pop_front());
      end
   end

   task automatic run_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_count();
      clr_i = 1'b1;
      @(negedge clk);
      clr_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      din_i = 7'h55;
      #2;
      n_cmp++;
      if (edge_o !== '0 || level_o !== '0 || any_edge_o !== 1'b0 || cnt_o !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_immediate: edge %h level %h any %b cnt %0d, need all 0", edge_o, level_o, any_edge_o, cnt_o);
      end
      run_cycles(2);
      n_cmp++;
      if (edge_o !== '0 || level_o !== '0 || any_edge_o !== 1'b0 || cnt_o !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_held: edge %h level %h any %b cnt %0d, need all 0", edge_o, level_o, any_edge_o, cnt_o);
      end
      rst = 1'b0;
      din_i = '0;
   endtask

   task automatic test_single_rise();
      int found;
      int pulses;
      logic [WIDTH-1:0] seen;
      found = -1; pulses = 0; seen = '0;
      mode_i = 2'b00;
      din_i = '0;
      run_cycles(LAT + 4);
      clear_count();
      din_i = 7'h01;
      for (int k = 0; k <= LAT + 4; k++) begin
         @(negedge clk);
         if (edge_o != '0) begin
            pulses++;
            if (found < 0) begin found = k; seen = edge_o; end
         end
      end
      n_cmp++;
      if (found != LAT) begin
         n_bad++;
         $display("FAIL rise_latency: pulse at edge %0d, need %0d", found, LAT);
      end
      n_cmp++;
      if (seen !== 7'h01 || pulses != 1) begin
         n_bad++;
         $display("FAIL rise_pulse: edge %h over %0d cycles, need 01 for 1 cycle", seen, pulses);
      end
      n_cmp++;
      if (level_o !== 7'h01 || cnt_o !== 8'd1) begin
         n_bad++;
         $display("FAIL rise_after: level %h cnt %0d, need 01 and 1", level_o, cnt_o);
      end
   endtask

   task automatic test_glitch();
      int bad_cycles;
      bad_cycles = 0;
      din_i[3] = 1'b1;
      run_cycles(EFF_DEB - 1);
      din_i[3] = 1'b0;
      for (int k = 0; k < LAT + 6; k++) begin
         @(negedge clk);
         if (edge_o !== m_edge || level_o !== m_stable || edge_o !== '0 || level_o[3] !== 1'b0 || cnt_o !== 8'd1)
            bad_cycles++;
      end
      n_cmp++;
      if (bad_cycles != 0) begin
         n_bad++;
         $display("FAIL glitch: %0d bad cycles (edge %h level %h cnt %0d), need 0", bad_cycles, edge_o, level_o, cnt_o);
      end
   endtask

   task automatic test_both_edges();
      int pulses;
      int any_hi;
      pulses = 0; any_hi = 0;
      din_i = '0;
      mode_i = 2'b10;
      run_cycles(LAT + 3);
      clear_count();
      din_i = 7'h7F;
      for (int k = 0; k < 40; k++) begin
         if (k == 20) din_i = '0;
         @(negedge clk);
         if (edge_o == 7'h7F) pulses++;
         if (any_edge_o) any_hi++;
      end
      n_cmp++;
      if (pulses != 2 || any_hi != 2) begin
         n_bad++;
         $display("FAIL both_edges: %0d full pulses, any high %0d cycles, need 2 and 2", pulses, any_hi);
      end
      n_cmp++;
      if (cnt_o !== 8'd14) begin
         n_bad++;
         $display("FAIL both_count: cnt %0d, need 14", cnt_o);
      end
   endtask

   task automatic test_mode_qualify();
      int rise_pulses;
      int fall_pulses;
      rise_pulses = 0; fall_pulses = 0;
      clear_count();
      mode_i = 2'b11;
      din_i = 7'h7F;
      for (int k = 0; k < LAT + 4; k++) begin
         @(negedge clk);
         if (edge_o != '0) rise_pulses++;
      end
      n_cmp++;
      if (rise_pulses != 0 || level_o !== 7'h7F) begin
         n_bad++;
         $display("FAIL mode_off_rise: %0d pulses level %h, need 0 and 7f", rise_pulses, level_o);
      end
      mode_i = 2'b01;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (edge_o != '0) rise_pulses++;
      end
      n_cmp++;
      if (rise_pulses != 0) begin
         n_bad++;
         $display("FAIL mode_change_alone: %0d pulses, need 0", rise_pulses);
      end
      din_i = '0;
      for (int k = 0; k < LAT + 4; k++) begin
         @(negedge clk);
         if (edge_o == 7'h7F) fall_pulses++;
      end
      n_cmp++;
      if (fall_pulses != 1 || level_o !== '0 || cnt_o !== 8'd7) begin
         n_bad++;
         $display("FAIL mode_fall: %0d pulses level %h cnt %0d, need 1, 00, 7", fall_pulses, level_o, cnt_o);
      end
   endtask

   task automatic test_saturate();
      int wait_cyc;
      mode_i = 2'b10;
      for (int t = 0; t < 40; t++) begin
         din_i = ~din_i;
         run_cycles(LAT + 2);
      end
      run_cycles(2);
      n_cmp++;
      if (cnt_o !== 8'd255) begin
         n_bad++;
         $display("FAIL saturate: cnt %0d, need 255", cnt_o);
      end
      din_i = ~din_i;
      wait_cyc = 0;
      @(negedge clk);
      while (edge_o == '0 && wait_cyc < LAT + 6) begin
         @(negedge clk);
         wait_cyc++;
      end
      n_cmp++;
      if (edge_o == '0) begin
         n_bad++;
         $display("FAIL saturate_pulse_timeout: edge %h, need nonzero", edge_o);
      end
      clr_i = 1'b1;
      @(negedge clk);
      clr_i = 1'b0;
      n_cmp++;
      if (cnt_o !== 8'd0) begin
         n_bad++;
         $display("FAIL clear_override: cnt %0d, need 0", cnt_o);
      end
   endtask

   task automatic test_reset_mid();
      int found;
      found = -1;
      mode_i = 2'b00;
      din_i = '0;
      run_cycles(LAT + 3);
      clear_count();
      din_i = 7'h01;
      run_cycles(4);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (edge_o !== '0 || level_o !== '0 || any_edge_o !== 1'b0 || cnt_o !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_mid: edge %h level %h any %b cnt %0d, need all 0", edge_o, level_o, any_edge_o, cnt_o);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k <= LAT + 4; k++) begin
         @(negedge clk);
         if (found < 0 && edge_o == 7'h01) found = k;
      end
      n_cmp++;
      if (found != LAT) begin
         n_bad++;
         $display("FAIL reset_release_pulse: pulse at edge %0d, need %0d", found, LAT);
      end
   endtask

   task automatic test_random();
      int bad_cycles;
      bad_cycles = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         n_cmp++;
         if (edge_o !== m_edge || level_o !== m_stable || any_edge_o !== (|m_edge) || cnt_o !== 8'(m_cnt)) begin
            n_bad++;
            bad_cycles++;
            if (bad_cycles <= 5)
               $display("FAIL random cyc %0d: edge %h/%h level %h/%h any %b cnt %0d/%0d (got/need)",
                        k, edge_o, m_edge, level_o, m_stable, any_edge_o, cnt_o, m_cnt);
         end
         rst = 1'b0;
         clr_i = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 30) == 0) mode_i = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 6) == 0) din_i = WIDTH'($urandom);
         else if ($urandom_range(0, 4) == 0) din_i[$urandom_range(0, WIDTH-1)] ^= 1'b1;
         if ($urandom_range(0, 400) == 0) rst = 1'b1;
      end
      rst = 1'b0;
      clr_i = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_single_rise();
      test_glitch();
      test_both_edges();
      test_mode_qualify();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
